rv32i_core: RTL and testbench

- Single-cycle RV32I processor with integrated unified instruction/data memory, 32-entry register file and a minimal machine-mode CSR file.
- Executes one instruction per rising clock edge from reset vector 0x0.
- Used standalone by riscv-tests style harnesses, which preload memory and probe pc and registers hierarchically.

---
 rtl/rv32i_core.sv | 238 +++++++++++++++++++++++
 tb/tb_rv32i_core.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv32i_core.sv
// rv32i_core: single-cycle RV32I processor with a unified byte-addressed
// memory, a 32-entry register file and a flat 4096-entry machine CSR array.
// Each rising edge retires exactly one instruction. Fetch, decode, execute
// and memory read are combinational; architectural state updates on the edge.

module rv32i_core_mem #(
   parameter int MEM_BYTES = 65536
) (
   input  logic        clk,
   input  logic        wen,
   input  logic [31:0] iaddr,
   output logic [31:0] idata,
   input  logic [31:0] daddr,
   output logic [31:0] ddata,
   input  logic [3:0]  we,
   input  logic [31:0] wdata
);
   // MEM_BYTES is a power of two, so wrap-around is plain truncation.
   localparam int AW = $clog2(MEM_BYTES);

   logic [7:0]    m [0:MEM_BYTES-1];
   logic [AW-1:0] ia_s;
   logic [AW-1:0] da_s;
   logic          unused_addr_s;

   assign ia_s          = iaddr[AW-1:0];
   assign da_s          = daddr[AW-1:0];
   assign unused_addr_s = ^{iaddr[31:AW], daddr[31:AW]};

   assign idata = {m[ia_s + AW'(3)], m[ia_s + AW'(2)], m[ia_s + AW'(1)], m[ia_s]};
   assign ddata = {m[da_s + AW'(3)], m[da_s + AW'(2)], m[da_s + AW'(1)], m[da_s]};

   // byte-lane stores; each lane wraps independently past the top of memory
   always_ff @(posedge clk) begin
      if (wen) begin
         if (we[0]) m[da_s]          <= wdata[7:0];
         if (we[1]) m[da_s + AW'(1)] <= wdata[15:8];
         if (we[2]) m[da_s + AW'(2)] <= wdata[23:16];
         if (we[3]) m[da_s + AW'(3)] <= wdata[31:24];
      end
   end
endmodule

module rv32i_core #(
   parameter int          MEM_BYTES = 65536,
   parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
   input logic clk,
   input logic rst
);
   localparam logic [6:0] OP_LUI   = 7'b0110111;
   localparam logic [6:0] OP_AUIPC = 7'b0010111;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_JALR  = 7'b1100111;
   localparam logic [6:0] OP_BR    = 7'b1100011;
   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;
   localparam logic [6:0] OP_IMM   = 7'b0010011;
   localparam logic [6:0] OP_REG   = 7'b0110011;
   localparam logic [6:0] OP_SYS   = 7'b1110011;

   logic [31:0] pc;
   logic [31:0] rs  [0:31];
   logic [31:0] csr [0:4095];

   logic [31:0] instr_s, dword_s, daddr_s, rv1_s, rv2_s, pc4_s;
   logic [31:0] imm_i_s, imm_s_s, imm_b_s, imm_u_s, imm_j_s, csr_old_s;
   logic [6:0]  opcode_s;
   logic [4:0]  rd_s, rs1a_s, rs2a_s;
   logic [2:0]  f3_s;
   logic [11:0] csr_addr_s;

   logic [31:0] next_pc_s, rd_val_s, csr_wdata_s, csr_src_s, cause_s;
   logic        rd_we_s, csr_we_s, trap_s;
   logic [3:0]  mem_we_s;

   function automatic logic [31:0] alu(input logic [2:0] f3, input logic alt,
                                       input logic [31:0] a, input logic [31:0] b);
      case (f3)
         3'd0:    return alt ? (a - b) : (a + b);
         3'd1:    return a << b[4:0];
         3'd2:    return {31'd0, $signed(a) < $signed(b)};
         3'd3:    return {31'd0, a < b};
         3'd4:    return a ^ b;
         3'd5:    return alt ? $unsigned($signed(a) >>> b[4:0]) : (a >> b[4:0]);
         3'd6:    return a | b;
         3'd7:    return a & b;
         default: return a + b;
      endcase
   endfunction

   function automatic logic br_taken(input logic [2:0] f3, input logic [31:0] a,
                                     input logic [31:0] b);
      case (f3)
         3'd0:    return a == b;
         3'd1:    return a != b;
         3'd4:    return $signed(a) < $signed(b);
         3'd5:    return $signed(a) >= $signed(b);
         3'd6:    return a < b;
         3'd7:    return a >= b;
         default: return 1'b0;
      endcase
   endfunction

   rv32i_core_mem #(.MEM_BYTES(MEM_BYTES)) memory (
      .clk   (clk),
      .wen   (rst),
      .iaddr (pc),
      .idata (instr_s),
      .daddr (daddr_s),
      .ddata (dword_s),
      .we    (mem_we_s),
      .wdata (rv2_s)
   );

   assign opcode_s   = instr_s[6:0];
   assign rd_s       = instr_s[11:7];
   assign f3_s       = instr_s[14:12];
   assign rs1a_s     = instr_s[19:15];
   assign rs2a_s     = instr_s[24:20];
   assign csr_addr_s = instr_s[31:20];

   assign rv1_s     = (rs1a_s == 5'd0) ? 32'd0 : rs[rs1a_s];
   assign rv2_s     = (rs2a_s == 5'd0) ? 32'd0 : rs[rs2a_s];
   assign csr_old_s = csr[csr_addr_s];
   assign pc4_s     = pc + 32'd4;

   assign imm_i_s = {{20{instr_s[31]}}, instr_s[31:20]};
   assign imm_s_s = {{20{instr_s[31]}}, instr_s[31:25], instr_s[11:7]};
   assign imm_b_s = {{19{instr_s[31]}}, instr_s[31], instr_s[7], instr_s[30:25], instr_s[11:8], 1'b0};
   assign imm_u_s = {instr_s[31:12], 12'h000};
   assign imm_j_s = {{11{instr_s[31]}}, instr_s[31], instr_s[19:12], instr_s[20], instr_s[30:21], 1'b0};
   assign daddr_s = rv1_s + ((opcode_s == OP_STORE) ? imm_s_s : imm_i_s);

   // decode and execute the current instruction
   always_comb begin
      next_pc_s   = pc4_s;
      rd_we_s     = 1'b0;
      rd_val_s    = 32'd0;
      mem_we_s    = 4'b0000;
      csr_we_s    = 1'b0;
      csr_wdata_s = 32'd0;
      csr_src_s   = 32'd0;
      trap_s      = 1'b0;
      cause_s     = 32'd0;
      case (opcode_s)
         OP_LUI:   begin rd_we_s = 1'b1; rd_val_s = imm_u_s; end
         OP_AUIPC: begin rd_we_s = 1'b1; rd_val_s = pc + imm_u_s; end
         OP_JAL: begin
            rd_we_s   = 1'b1;
            rd_val_s  = pc4_s;
            next_pc_s = pc + imm_j_s;
         end
         OP_JALR: begin
            rd_we_s   = 1'b1;
            rd_val_s  = pc4_s;
            next_pc_s = (rv1_s + imm_i_s) & 32'hFFFF_FFFE;
         end
         OP_BR: begin
            if (br_taken(f3_s, rv1_s, rv2_s)) next_pc_s = pc + imm_b_s;
            else                              next_pc_s = pc4_s;
         end
         OP_LOAD: begin
            case (f3_s)
               3'd0:    begin rd_we_s = 1'b1; rd_val_s = {{24{dword_s[7]}}, dword_s[7:0]}; end
               3'd1:    begin rd_we_s = 1'b1; rd_val_s = {{16{dword_s[15]}}, dword_s[15:0]}; end
               3'd2:    begin rd_we_s = 1'b1; rd_val_s = dword_s; end
               3'd4:    begin rd_we_s = 1'b1; rd_val_s = {24'd0, dword_s[7:0]}; end
               3'd5:    begin rd_we_s = 1'b1; rd_val_s = {16'd0, dword_s[15:0]}; end
               default: rd_we_s = 1'b0;
            endcase
         end
         OP_STORE: begin
            case (f3_s)
               3'd0:    mem_we_s = 4'b0001;
               3'd1:    mem_we_s = 4'b0011;
               3'd2:    mem_we_s = 4'b1111;
               default: mem_we_s = 4'b0000;
            endcase
         end
         OP_IMM: begin
            rd_we_s  = 1'b1;
            // only SRAI borrows bit 30; an ADDI immediate may have it set
            rd_val_s = alu(f3_s, (f3_s == 3'd5) ? instr_s[30] : 1'b0, rv1_s, imm_i_s);
         end
         OP_REG: begin
            rd_we_s  = 1'b1;
            rd_val_s = alu(f3_s, instr_s[30], rv1_s, rv2_s);
         end
         OP_SYS: begin
            if (f3_s == 3'd0) begin
               case (csr_addr_s)
                  12'h000: begin trap_s = 1'b1; cause_s = 32'd11; next_pc_s = csr[12'h305]; end
                  12'h001: begin trap_s = 1'b1; cause_s = 32'd3;  next_pc_s = csr[12'h305]; end
                  12'h302: next_pc_s = csr[12'h341];
                  default: next_pc_s = pc4_s;
               endcase
            end else if (f3_s != 3'd4) begin
               rd_we_s   = 1'b1;
               rd_val_s  = csr_old_s;
               csr_src_s = f3_s[2] ? {27'd0, rs1a_s} : rv1_s;
               case (f3_s[1:0])
                  2'b01:   begin csr_we_s = 1'b1; csr_wdata_s = csr_src_s; end
                  2'b10:   begin csr_we_s = (rs1a_s != 5'd0); csr_wdata_s = csr_old_s | csr_src_s; end
                  2'b11:   begin csr_we_s = (rs1a_s != 5'd0); csr_wdata_s = csr_old_s & ~csr_src_s; end
                  default: csr_we_s = 1'b0;
               endcase
            end else begin
               rd_we_s = 1'b0;
            end
         end
         default: next_pc_s = pc4_s;
      endcase
   end

   // program counter and register file; x0 is never written
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pc <= RESET_PC;
         for (int i = 0; i < 32; i++) rs[i] <= 32'd0;
      end else begin
         pc <= next_pc_s;
         if (rd_we_s && (rd_s != 5'd0)) rs[rd_s] <= rd_val_s;
      end
   end

   // CSR array: trap bookkeeping or CSR instruction write; not cleared by reset
   always_ff @(posedge clk) begin
      if (rst) begin
         if (trap_s) begin
            csr[12'h341] <= pc;
            csr[12'h342] <= cause_s;
         end else if (csr_we_s) begin
            csr[csr_addr_s] <= csr_wdata_s;
         end
      end
   end
endmodule

// File: tb/tb_rv32i_core.sv
// tb_rv32i_core: directed programs preloaded into memory; expected
// architectural state is queued as each program is loaded and checked once
// the program has run its cycle budget.

module tb_rv32i_core;
   localparam logic [6:0] LUI = 7'h37, AUIPC = 7'h17, JALR = 7'h67;
   localparam logic [6:0] LOAD = 7'h03, STORE = 7'h23, OPI = 7'h13, OPR = 7'h33, SYS = 7'h73;

   logic clk;
   logic rst;

   typedef struct {
      string       tag;
      int          kind;   // 0 reg, 1 pc, 2 csr, 3 memory byte
      int          idx;
      logic [31:0] exp;
   } sb_t;

   sb_t sbq[$];
   int  n_cmp = 0;
   int  n_mis = 0;

   rv32i_core #(.MEM_BYTES(65536), .RESET_PC(32'h0000_0000)) dut (.clk(clk), .rst(rst));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] enc_i(input logic [31:0] imm, input logic [4:0] rs1,
                                         input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
      return {imm[11:0], rs1, f3, rd, op};
   endfunction
   function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                         input logic [2:0] f3, input logic [4:0] rd);
      return {f7, rs2, rs1, f3, rd, OPR};
   endfunction
   function automatic logic [31:0] enc_s(input logic [31:0] imm, input logic [4:0] rs2,
                                         input logic [4:0] rs1, input logic [2:0] f3);
      return {imm[11:5], rs2, rs1, f3, imm[4:0], STORE};
   endfunction
   function automatic logic [31:0] enc_b(input logic [31:0] imm, input logic [4:0] rs2,
                                         input logic [4:0] rs1, input logic [2:0] f3);
      return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
   endfunction
   function automatic logic [31:0] enc_u(input logic [31:0] imm20, input logic [4:0] rd, input logic [6:0] op);
      return {imm20[19:0], rd, op};
   endfunction
   function automatic logic [31:0] enc_j(input logic [31:0] imm, input logic [4:0] rd);
      return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6F};
   endfunction

   task automatic mw(input logic [15:0] a, input logic [31:0] w);
      for (int k = 0; k < 4; k++) dut.memory.m[a + 16'(k)] = w[8*k +: 8];
   endtask

   task automatic push(input string tag, input int kind, input int idx, input logic [31:0] exp);
      sb_t e;
      e.tag = tag; e.kind = kind; e.idx = idx; e.exp = exp;
      sbq.push_back(e);
   endtask

   function automatic logic [31:0] probe(input int kind, input int idx);
      case (kind)
         0:       return dut.rs[idx];
         1:       return dut.pc;
         2:       return dut.csr[idx];
         3:       return {24'd0, dut.memory.m[idx]};
         default: return 32'hxxxx_xxxx;
      endcase
   endfunction

   task automatic drain();
      sb_t         e;
      logic [31:0] obs;
      while (sbq.size() > 0) begin
         e   = sbq.pop_front();
         obs = probe(e.kind, e.idx);
         n_cmp++;
         assert (obs === e.exp) else begin
            n_mis++;
            $error("FAIL %s: observed %h expected %h", e.tag, obs, e.exp);
         end
      end
   endtask

   task automatic run(input int n);
      repeat (n) @(posedge clk);
      @(negedge clk);
   endtask

   // assert reset between edges, check async clear, then clear memory
   task automatic begin_test();
      rst = 1'b0;
      #1;
      push("rst_pc", 1, 0, 32'h0);
      for (int i = 0; i < 32; i++) push($sformatf("rst_x%0d", i), 0, i, 32'h0);
      drain();
      for (int a = 0; a < 65536; a++) dut.memory.m[a] = 8'h00;
   endtask

   task automatic release_rst();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      push("rel_pc", 1, 0, 32'h0);
      drain();
   endtask

   initial begin
      rst = 1'b0;
      @(negedge clk);

      // ---------------- ALU ----------------
      begin_test();
      mw(16'h00, enc_i(-1, 0, 0, 1, OPI));
      mw(16'h04, enc_i(2, 1, 0, 2, OPI));
      mw(16'h08, enc_i(1, 1, 3, 3, OPI));
      mw(16'h0C, enc_i(5, 0, 0, 0, OPI));
      mw(16'h10, enc_r(7'h20, 1, 0, 0, 4));
      mw(16'h14, enc_r(7'h00, 2, 1, 5, 5));
      mw(16'h18, enc_r(7'h00, 0, 1, 2, 6));
      mw(16'h1C, enc_r(7'h00, 0, 1, 3, 7));
      mw(16'h20, enc_u(32'h12345, 8, LUI));
      mw(16'h24, enc_u(32'h1, 9, AUIPC));
      mw(16'h28, enc_i(31, 2, 1, 10, OPI));
      mw(16'h2C, enc_i(32'h404, 10, 5, 11, OPI));
      mw(16'h30, enc_r(7'h20, 2, 11, 5, 12));
      mw(16'h34, enc_i(32'h7F0, 0, 4, 13, OPI));
      mw(16'h38, enc_i(-16, 13, 7, 14, OPI));
      mw(16'h3C, enc_i(32'h00F, 13, 6, 15, OPI));
      mw(16'h40, enc_i(32'h400, 0, 0, 16, OPI));
      release_rst();
      push("addi_neg", 0, 1, 32'hFFFF_FFFF);
      push("addi_wrap", 0, 2, 32'h1);
      push("sltiu", 0, 3, 32'h0);
      push("alu_pc", 1, 0, 32'hC);
      run(3); drain();
      push("x0_const", 0, 0, 32'h0);
      push("x0_pc", 1, 0, 32'h10);
      run(1); drain();
      push("sub", 0, 4, 32'h1);
      push("srl", 0, 5, 32'h7FFF_FFFF);
      push("slt", 0, 6, 32'h1);
      push("sltu", 0, 7, 32'h0);
      push("lui", 0, 8, 32'h1234_5000);
      push("auipc", 0, 9, 32'h0000_1024);
      push("slli", 0, 10, 32'h8000_0000);
      push("srai", 0, 11, 32'hF800_0000);
      push("sra", 0, 12, 32'hFC00_0000);
      push("xori", 0, 13, 32'h7F0);
      push("andi", 0, 14, 32'h7F0);
      push("ori", 0, 15, 32'h7FF);
      push("addi_b30", 0, 16, 32'h400);
      push("alu_end_pc", 1, 0, 32'h44);
      run(13); drain();

      // ---------------- load / store ----------------
      begin_test();
      mw(16'h00, enc_u(32'h80008, 1, LUI));
      mw(16'h04, enc_i(1, 1, 0, 1, OPI));
      mw(16'h08, enc_i(32'h100, 0, 0, 2, OPI));
      mw(16'h0C, enc_s(0, 1, 2, 2));
      mw(16'h10, enc_i(0, 2, 0, 3, LOAD));
      mw(16'h14, enc_i(3, 2, 4, 4, LOAD));
      mw(16'h18, enc_i(2, 2, 1, 5, LOAD));
      mw(16'h1C, enc_i(2, 2, 5, 6, LOAD));
      mw(16'h20, enc_i(32'h7AB, 0, 0, 7, OPI));
      mw(16'h24, enc_s(0, 7, 2, 0));
      mw(16'h28, enc_i(0, 2, 2, 8, LOAD));
      mw(16'h2C, enc_s(1, 7, 2, 1));
      mw(16'h30, enc_i(0, 2, 2, 9, LOAD));
      mw(16'h34, enc_s(-2, 1, 0, 2));
      mw(16'h38, enc_i(-2, 0, 2, 10, LOAD));
      mw(16'h3C, enc_i(1, 0, 4, 11, LOAD));
      mw(16'h40, enc_i(-1, 0, 0, 12, LOAD));
      release_rst();
      push("lb", 0, 3, 32'h0000_0001);
      push("lbu", 0, 4, 32'h0000_0080);
      push("lh", 0, 5, 32'hFFFF_8000);
      push("lhu", 0, 6, 32'h0000_8000);
      push("sb_lw", 0, 8, 32'h8000_80AB);
      push("sh_mis_lw", 0, 9, 32'h8007_ABAB);
      push("lw_wrap", 0, 10, 32'h8000_8001);
      push("lbu_wrap", 0, 11, 32'h0000_0080);
      push("lb_top", 0, 12, 32'hFFFF_FF80);
      push("m100", 3, 32'h100, 32'hAB);
      push("m102", 3, 32'h102, 32'h07);
      push("m104", 3, 32'h104, 32'h00);
      push("mFFFE", 3, 32'hFFFE, 32'h01);
      push("m0001", 3, 32'h0001, 32'h80);
      push("ls_pc", 1, 0, 32'h44);
      run(17); drain();

      // ---------------- control flow ----------------
      begin_test();
      mw(16'h00, enc_i(32'h40, 0, 0, 6, OPI));
      mw(16'h04, enc_i(2, 0, 0, 1, OPI));
      mw(16'h08, enc_j(32'h10, 14));
      mw(16'h18, enc_i(-1, 1, 0, 1, OPI));
      mw(16'h1C, enc_i(1, 12, 0, 12, OPI));
      mw(16'h20, enc_b(-8, 0, 1, 1));
      mw(16'h24, enc_i(3, 6, 0, 5, JALR));
      mw(16'h42, enc_i(7, 0, 0, 13, OPI));
      mw(16'h46, enc_i(-1, 0, 0, 2, OPI));
      mw(16'h4A, enc_b(8, 2, 1, 6));
      mw(16'h52, enc_b(8, 1, 2, 5));
      mw(16'h56, enc_b(16, 0, 0, 0));
      release_rst();
      push("bne_taken_pc", 1, 0, 32'h18);
      run(6); drain();
      push("jalr_pc", 1, 0, 32'h42);
      push("jalr_link", 0, 5, 32'h28);
      push("jal_link", 0, 14, 32'hC);
      push("loop_cnt", 0, 12, 32'h2);
      run(4); drain();
      push("mis_fetch", 0, 13, 32'h7);
      push("br_mix_pc", 1, 0, 32'h66);
      run(5); drain();

      // ---------------- CSR / trap ----------------
      begin_test();
      mw(16'h00, enc_j(32'h10, 0));
      mw(16'h04, enc_i(32'h302, 0, 0, 0, SYS));
      mw(16'h10, enc_i(4, 0, 0, 7, OPI));
      mw(16'h14, enc_i(32'h305, 7, 1, 0, SYS));
      mw(16'h18, enc_i(32'h340, 5'h15, 5, 0, SYS));
      mw(16'h1C, enc_i(32'h340, 5'h0A, 6, 8, SYS));
      mw(16'h20, enc_i(32'h340, 5'h03, 7, 9, SYS));
      mw(16'h24, enc_i(32'h340, 0, 2, 10, SYS));
      mw(16'h28, enc_i(32'h340, 7, 3, 11, SYS));
      mw(16'h2C, enc_i(32'h340, 0, 2, 12, SYS));
      mw(16'h30, enc_i(32'h000, 0, 0, 0, SYS));
      release_rst();
      push("ecall_pc", 1, 0, 32'h4);
      push("mtvec", 2, 32'h305, 32'h4);
      push("mepc", 2, 32'h341, 32'h30);
      push("mcause_ecall", 2, 32'h342, 32'd11);
      push("csrrsi_old", 0, 8, 32'h15);
      push("csrrci_old", 0, 9, 32'h1F);
      push("csrrs_x0", 0, 10, 32'h1C);
      push("csrrc_old", 0, 11, 32'h1C);
      push("csrrc_res", 0, 12, 32'h18);
      push("mscratch", 2, 32'h340, 32'h18);
      run(10); drain();
      push("mret_pc", 1, 0, 32'h30);
      run(1); drain();

      // ---------------- no-ops and EBREAK ----------------
      begin_test();
      mw(16'h00, enc_i(32'h20, 0, 0, 7, OPI));
      mw(16'h04, 32'h0000_000F);
      mw(16'h08, 32'hFFFF_FFFF);
      mw(16'h0C, enc_i(32'h305, 7, 1, 0, SYS));
      mw(16'h10, enc_i(32'h001, 0, 0, 0, SYS));
      release_rst();
      push("ebreak_pc", 1, 0, 32'h20);
      push("ebreak_mepc", 2, 32'h341, 32'h10);
      push("mcause_ebreak", 2, 32'h342, 32'd3);
      push("unknown_nop", 0, 31, 32'h0);
      run(5); drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end
endmodule
